// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and default widths for the register-file write-back arbiter.
package rf_wb_arbiter_pkg;

  localparam int RF_DATA_WID = 32;
  localparam int RF_ADDR_WID = 5;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [RF_ADDR_WID-1:0] addr;
    logic [RF_DATA_WID-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO buffering long-latency write-back requests.
module rf_wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW:0]      wptr_q, wptr_d;
  logic [PW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q[PW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + (PW+1)'(1);
    if (do_pop)  rptr_d = rptr_q + (PW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU results win, long-latency results are
// buffered and periodically forced through; tracks pending writes for hazards.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_WID   = RF_DATA_WID,
  parameter int ADDR_WID   = RF_ADDR_WID,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  input  logic [ADDR_WID-1:0] alu_addr,
  input  logic [DATA_WID-1:0] alu_data,
  output logic                alu_hold,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [ADDR_WID-1:0] mem_addr,
  input  logic [DATA_WID-1:0] mem_data,
  input  logic                iss_valid,
  input  logic [ADDR_WID-1:0] iss_addr,
  output logic                iss_ready,
  input  logic [ADDR_WID-1:0] chk_r1,
  input  logic [ADDR_WID-1:0] chk_r2,
  input  logic [ADDR_WID-1:0] chk_wd,
  output logic                stall,
  output logic                rf_we,
  output logic [ADDR_WID-1:0] rf_addr,
  output logic [DATA_WID-1:0] rf_din
);

  localparam int NREG = 2**ADDR_WID;
  localparam int SW   = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef struct packed {
    logic [ADDR_WID-1:0] addr;
    logic [DATA_WID-1:0] data;
  } req_t;

  arb_state_e          state_q, state_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [CNT_W-1:0]    pend_q [NREG];
  logic [CNT_W-1:0]    pend_d [NREG];
  logic [NREG-1:0]     inc_v, dec_v;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_WID-1:0] rf_addr_q;
  logic [DATA_WID-1:0] rf_din_q;
  req_t                fifo_din, fifo_dout, win;
  logic                fifo_full, fifo_empty, push, pop, alu_acc, win_vld;

  assign alu_hold  = (state_q == ST_DRAIN);
  assign alu_acc   = alu_valid && !alu_hold;
  assign mem_ready = !fifo_full;
  assign push      = mem_valid && !fifo_full;
  assign fifo_din  = {mem_addr, mem_data};

  // Arrivals always land in the FIFO first; the head is only visible a cycle later.
  rf_wb_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    pop      = 1'b0;
    win_vld  = 1'b0;
    win      = fifo_dout;
    case (state_q)
      ST_NORMAL: begin
        if (alu_acc) begin
          win_vld = 1'b1;
          win     = {alu_addr, alu_data};
          if (fifo_empty) begin
            starve_d = '0;
          end else begin
            starve_d = starve_q + SW'(1);
            if (starve_d == STARVE_LIM) state_d = ST_DRAIN;
          end
        end else begin
          starve_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            win_vld = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        pop      = !fifo_empty;
        win_vld  = !fifo_empty;
        state_d  = ST_NORMAL;
        starve_d = '0;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // Register 0 is consumed silently: no write strobe, no scoreboard entry.
  assign rf_we_d = win_vld && (win.addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_NORMAL;
      starve_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_din_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rf_we_q  <= rf_we_d;
      if (rf_we_d) begin
        rf_addr_q <= win.addr;
        rf_din_q  <= win.data;
      end
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_addr = rf_addr_q;
  assign rf_din  = rf_din_q;

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (iss_valid && (iss_addr != '0))   inc_v[iss_addr]       = 1'b1;
    if (pop && (fifo_dout.addr != '0))  dec_v[fifo_dout.addr] = 1'b1;
  end

  // Counters saturate on over-issue and never underflow on an unmatched retire.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      pend_d[i] = pend_q[i];
      if (inc_v[i] && !dec_v[i] && (pend_q[i] != CNT_MAX))
        pend_d[i] = pend_q[i] + CNT_W'(1);
      else if (dec_v[i] && !inc_v[i] && (pend_q[i] != '0))
        pend_d[i] = pend_q[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) pend_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign iss_ready = (pend_q[iss_addr] != CNT_MAX);
  assign stall     = ((chk_r1 != '0) && (pend_q[chk_r1] != '0)) ||
                     ((chk_r2 != '0) && (pend_q[chk_r2] != '0)) ||
                     ((chk_wd != '0) && (pend_q[chk_wd] != '0));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with an in-order write-port scoreboard.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_hold, mem_valid, mem_ready, iss_valid, iss_ready;
  logic [4:0]  alu_addr, mem_addr, iss_addr, chk_r1, chk_r2, chk_wd, rf_addr;
  logic [31:0] alu_data, mem_data, rf_din;
  logic        stall, rf_we;

  int n_vec = 0;
  int n_err = 0;
  wr_req_t exp_q[$];

  rf_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_hold  (alu_hold),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .chk_r1    (chk_r1),
    .chk_r2    (chk_r2),
    .chk_wd    (chk_wd),
    .stall     (stall),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_din    (rf_din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_req_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, check the combinational handshakes, then advance.
  task automatic run_cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                           input logic mv, input logic [4:0] ma, input logic [31:0] md,
                           input logic iv, input logic [4:0] ia,
                           input logic eh, input logic er, input string tag);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    iss_valid = iv; iss_addr = ia;
    #1;
    chk({tag, "_hold"}, alu_hold, eh);
    chk({tag, "_ready"}, mem_ready, er);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, tag);
  endtask

  // Write-port monitor: every rf_we must match the next expected write in order.
  always @(posedge clk) begin
    wr_req_t e;
    #1;
    if (rf_we) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got addr=%0d data=%0h, required no write", rf_addr, rf_din);
      end else begin
        e = exp_q.pop_front();
        if (rf_addr !== e.addr || rf_din !== e.data) begin
          n_err++;
          $display("FAIL wr_order: got addr=%0d data=%0h, required addr=%0d data=%0h",
                   rf_addr, rf_din, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n = 1'b0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    iss_valid = 0; iss_addr = 0;
    chk_r1 = 0; chk_r2 = 0; chk_wd = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_we", rf_we, 0);
    chk("rst_addr", rf_addr, 0);
    chk("rst_din", rf_din, 0);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_iss_ready", iss_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_hold", alu_hold, 0);
    rst_n = 1'b1;

    // ALU-only write, one cycle latency
    expect_wr(3, 32'h1234);
    run_cycle(1, 3, 32'h1234, 0, 0, 0, 0, 0, 0, 1, "t1");
    chk("t1_we", rf_we, 1);
    chk("t1_addr", rf_addr, 3);
    chk("t1_din", rf_din, 32'h1234);
    idle(1, "t1i");
    chk("t1_we_low", rf_we, 0);

    // Register 0: write and issue both vanish
    chk_r1 = 0;
    run_cycle(1, 0, 32'hFFFF, 0, 0, 0, 1, 0, 0, 1, "t2");
    chk("t2_we_zero", rf_we, 0);
    chk("t2_stall", stall, 0);
    idle(1, "t2i");
    chk("t2_stall_b", stall, 0);

    // Scoreboard set and clear on reg 7
    chk_r1 = 7;
    #1 chk("t3_stall_pre", stall, 0);
    expect_wr(7, 32'hAA);
    run_cycle(0, 0, 0, 0, 0, 0, 1, 7, 0, 1, "t3a");
    chk("t3_stall_set", stall, 1);
    run_cycle(0, 0, 0, 1, 7, 32'hAA, 0, 0, 0, 1, "t3b");
    chk("t3_stall_buf", stall, 1);
    chk("t3_we_not_yet", rf_we, 0);
    idle(1, "t3c");
    chk("t3_we", rf_we, 1);
    chk("t3_stall_clr", stall, 0);

    // Counter saturation on reg 12 and staged retirement
    chk_r1 = 12;
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0, 0, 0, 1, 12, 0, 1, "t4i");
    iss_valid = 0; iss_addr = 12;
    #1 chk("t4_iss_ready_sat", iss_ready, 0);
    iss_addr = 13;
    #1 chk("t4_iss_ready_other", iss_ready, 1);
    expect_wr(12, 32'hC0); expect_wr(12, 32'hC1); expect_wr(12, 32'hC2);
    run_cycle(0, 0, 0, 1, 12, 32'hC0, 0, 0, 0, 1, "t4m0");
    run_cycle(0, 0, 0, 1, 12, 32'hC1, 0, 0, 0, 1, "t4m1");
    run_cycle(0, 0, 0, 1, 12, 32'hC2, 0, 0, 0, 1, "t4m2");
    chk("t4_stall_one_left", stall, 1);
    idle(1, "t4d");
    chk("t4_stall_clr", stall, 0);
    iss_addr = 12;
    #1 chk("t4_iss_ready_free", iss_ready, 1);
    idle(2, "t4e");

    // Starvation: 3 ALU wins with a waiting entry, then one forced drain
    expect_wr(16, 32'hA0); expect_wr(17, 32'hA1); expect_wr(18, 32'hA2);
    expect_wr(19, 32'hA3); expect_wr(5, 32'h55);  expect_wr(20, 32'hA4);
    expect_wr(21, 32'hA5);
    run_cycle(1, 16, 32'hA0, 1, 5, 32'h55, 1, 5, 0, 1, "t5k0");
    run_cycle(1, 17, 32'hA1, 0, 0, 0, 0, 0, 0, 1, "t5k1");
    run_cycle(1, 18, 32'hA2, 0, 0, 0, 0, 0, 0, 1, "t5k2");
    run_cycle(1, 19, 32'hA3, 0, 0, 0, 0, 0, 0, 1, "t5k3");
    run_cycle(1, 20, 32'hA4, 0, 0, 0, 0, 0, 1, 1, "t5k4");
    run_cycle(1, 20, 32'hA4, 0, 0, 0, 0, 0, 0, 1, "t5k5");
    run_cycle(1, 21, 32'hA5, 0, 0, 0, 0, 0, 0, 1, "t5k6");
    idle(2, "t5i");

    // Full FIFO while ALU busy; retirement order 1..4
    expect_wr(22, 32'hB0); expect_wr(23, 32'hB1); expect_wr(24, 32'hB2); expect_wr(25, 32'hB3);
    for (int i = 1; i <= 4; i++) expect_wr(5'(i), 32'h100 + i);
    run_cycle(1, 22, 32'hB0, 1, 1, 32'h101, 1, 1, 0, 1, "t6k0");
    run_cycle(1, 23, 32'hB1, 1, 2, 32'h102, 1, 2, 0, 1, "t6k1");
    run_cycle(1, 24, 32'hB2, 1, 3, 32'h103, 1, 3, 0, 1, "t6k2");
    run_cycle(1, 25, 32'hB3, 1, 4, 32'h104, 1, 4, 0, 1, "t6k3");
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "t6k4");
    idle(4, "t6i");
    chk("t6_q_empty", exp_q.size(), 0);

    // Asynchronous reset with two buffered entries and pend[9]=1
    chk_r1 = 9;
    expect_wr(26, 32'hC6); expect_wr(27, 32'hC7);
    run_cycle(1, 26, 32'hC6, 1, 9, 32'h99, 1, 9, 0, 1, "t7k0");
    run_cycle(1, 27, 32'hC7, 1, 11, 32'hBB, 0, 0, 0, 1, "t7k1");
    alu_valid = 0; mem_valid = 0; iss_valid = 0; iss_addr = 9;
    chk("t7_stall_pre", stall, 1);
    chk("t7_q_empty_pre", exp_q.size(), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_we", rf_we, 0);
    chk("t7_rst_stall", stall, 0);
    chk("t7_rst_mem_ready", mem_ready, 1);
    chk("t7_rst_iss_ready", iss_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5, "t7i");
    chk("t7_stall_post", stall, 0);
    chk("t7_we_post", rf_we, 0);
    chk("final_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Sits on the initiator side of the register file write port and is the only block that drives rf_we, rf_addr and rf_din.
- Merges two write sources onto that single port:
  - single-cycle ALU results, which have priority;
  - long-latency load/MDU results, which are buffered in a FIFO.
- Keeps a per-register pending scoreboard so the decode stage can stall on RAW/WAW hazards against outstanding long-latency writes.
- Prevents FIFO starvation by periodically forcing the ALU to hold.

Parameters:
- DATA_WID, 32, register data width
- ADDR_WID, 5, register address width (2**ADDR_WID registers)
- FIFO_DEPTH, 4, entries in the long-latency write buffer (power of 2, at least 2)
- CNT_W, 2, width of the per-register pending counter
- STARVE_MAX, 3, consecutive ALU-won cycles with a non-empty FIFO before a forced drain

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result valid
- alu_addr  in  ADDR_WID  ALU destination register
- alu_data  in  DATA_WID  ALU result
- alu_hold  out  1  ALU must hold its result this cycle; combinational from state
- mem_valid  in  1  long-latency result valid
- mem_ready  out  1  FIFO can accept; equals !full
- mem_addr  in  ADDR_WID  long-latency destination register
- mem_data  in  DATA_WID  long-latency result
- iss_valid  in  1  long-latency op issued to iss_addr
- iss_addr  in  ADDR_WID  destination of the issued op
- iss_ready  out  1  pending counter of iss_addr is not saturated
- chk_r1  in  ADDR_WID  decode source register 1
- chk_r2  in  ADDR_WID  decode source register 2
- chk_wd  in  ADDR_WID  decode destination register
- stall  out  1  any checked register has a pending write
- rf_we  out  1  register file write enable (registered)
- rf_addr  out  ADDR_WID  register file write address (registered)
- rf_din  out  DATA_WID  register file write data (registered)

Behaviour:
- Reset: rf_we=0, rf_addr=0, rf_din=0, FIFO empty, all pending counters 0, starve counter 0, FSM in NORMAL.
  - Outputs after reset: mem_ready=1, iss_ready=1, stall=0, alu_hold=0.
- Write-port timing:
  - A winner is selected each cycle and registered at posedge.
  - rf_we/rf_addr/rf_din are therefore valid for the whole following cycle.
  - The register file commits at that cycle's negedge. Latency is 1 cycle from acceptance to rf_we.
- Register 0:
  - Writes addressed to 0 are accepted and consumed but never raise rf_we.
  - Register 0 is never marked pending and never causes a stall.
- Handshakes:
  - ALU: accepted when alu_valid && !alu_hold.
  - mem: accepted into the FIFO when mem_valid && mem_ready. Simultaneous push and pop on a full FIFO is not allowed; mem_ready is driven purely from full.
- Arbitration, FSM states NORMAL and DRAIN:
  - NORMAL, accepted ALU write present: the ALU wins. If the FIFO is non-empty, starve_cnt increments.
  - NORMAL, no accepted ALU write: the FIFO head wins if non-empty; starve_cnt resets to 0.
  - NORMAL → DRAIN when starve_cnt reaches STARVE_MAX and the FIFO is non-empty.
  - DRAIN: alu_hold=1 and the FIFO head wins for exactly one cycle, then the FSM returns to NORMAL with starve_cnt=0. If the FIFO empties first, it returns to NORMAL directly.
  - Bypass: a mem write arriving on the same cycle into an empty FIFO is not written the same cycle. It is pushed first, which gives a minimum 1 cycle of buffering.
- Scoreboard:
  - Issue: iss_valid with a nonzero iss_addr increments pend[iss_addr].
  - Retire: a FIFO pop with a nonzero address decrements pend[addr].
  - Both on the same address in the same cycle: net zero change.
  - iss_ready = pend[iss_addr] != max. The issuer must not assert iss_valid when iss_ready=0; if it does, the increment saturates.
  - stall = OR over chk_r1, chk_r2, chk_wd of (addr != 0 && pend[addr] != 0). Combinational, computed from the registered counters.
  - The decrement takes effect at the same posedge that rf_we rises. stall drops in the cycle in which the register file write commits at negedge, so the next posedge read sees the new value.
- A mem write whose address has pend=0 is a protocol error: the counter does not underflow, and the write still occurs.
- Reset mid-operation flushes the FIFO and the scoreboard, and drops any buffered writes.

Decomposition:
- Shared package:
  - DATA_WID and ADDR_WID constants
  - FSM state typedef (NORMAL, DRAIN)
  - write-request struct {addr, data}
- One natural sub-module: rf_wb_fifo, a synchronous FIFO with parameterised depth and width.
  - Ports: push, pop, din, dout, full, empty.
- Scoreboard and arbiter stay in the top level.

Test Plan:
- ALU-only write: alu_valid=1, alu_addr=3, alu_data=0x1234 for 1 cycle → next cycle rf_we=1, rf_addr=3, rf_din=0x1234; the following cycle rf_we=0.
- Zero-register write: alu_addr=0, data=0xFFFF → rf_we stays 0; iss_valid with iss_addr=0 → stall never asserts for chk_r1=0.
- Scoreboard:
  - iss_valid with iss_addr=7 → with chk_r1=7, stall=1 from the next cycle.
  - mem write {7, 0xAA} pushed → rf_we with rf_addr=7 and rf_din=0xAA two cycles later, and stall=0 in that same cycle.
- Priority and starvation:
  - FIFO holds {5, 0x55}, alu_valid held high for 6 cycles with STARVE_MAX=3.
  - Required: 3 ALU writes, then alu_hold=1 and the write {5, 0x55}, then ALU writes resume.
- Full FIFO:
  - Push FIFO_DEPTH=4 mem writes while the ALU is busy → mem_ready=0 after the 4th push.
  - Retirement order is preserved: addresses 1, 2, 3, 4 appear in that order.
- Async reset:
  - Assert rst_n=0 mid-cycle with the FIFO at 2 entries and pend[9]=1.
  - Required immediately: rf_we=0, stall=0 for chk_r1=9, mem_ready=1. No buffered write appears after reset is released.
